// File: rtl/dcache_tcm_responder_pkg.sv
// Shared request/response types, FSM states and the AMO datapath for the TCM responder.
// Field layout follows the HPDCache core-side request/response protocol.
package drac_pkg;

    localparam int ADDR_W = 40;
    localparam int TID_W  = 8;
    localparam int SID_W  = 3;

    typedef enum logic [3:0] {
        HPDCACHE_REQ_LOAD     = 4'h0,
        HPDCACHE_REQ_STORE    = 4'h1,
        HPDCACHE_REQ_AMO_LR   = 4'h4,
        HPDCACHE_REQ_AMO_SC   = 4'h5,
        HPDCACHE_REQ_AMO_SWAP = 4'h6,
        HPDCACHE_REQ_AMO_ADD  = 4'h7,
        HPDCACHE_REQ_AMO_AND  = 4'h8,
        HPDCACHE_REQ_AMO_OR   = 4'h9,
        HPDCACHE_REQ_AMO_XOR  = 4'ha,
        HPDCACHE_REQ_AMO_MAX  = 4'hb,
        HPDCACHE_REQ_AMO_MAXU = 4'hc,
        HPDCACHE_REQ_AMO_MIN  = 4'hd,
        HPDCACHE_REQ_AMO_MINU = 4'he
    } hpdcache_req_op_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       wdata;
        hpdcache_req_op_t  op;
        logic [7:0]        be;
        logic [2:0]        size;
        logic [SID_W-1:0]  sid;
        logic [TID_W-1:0]  tid;
        logic              need_rsp;
        logic              uncacheable;
    } hpdcache_req_t;

    typedef struct packed {
        logic [63:0]      rdata;
        logic [SID_W-1:0] sid;
        logic [TID_W-1:0] tid;
        logic             error;
    } hpdcache_rsp_t;

    typedef enum logic {IDLE, AMO_WR} tcm_fsm_t;

    typedef struct packed {
        logic             valid;
        logic [TID_W-1:0] tid;
        logic [SID_W-1:0] sid;
        logic [63:0]      rdata;
        logic             error;
    } tcm_rsp_entry_t;

    function automatic logic is_amo(hpdcache_req_op_t op);
        return op >= HPDCACHE_REQ_AMO_LR;
    endfunction

    function automatic logic is_amo_rmw(hpdcache_req_op_t op);
        return op >= HPDCACHE_REQ_AMO_SWAP;
    endfunction

    // Result is replicated into both 32-bit lanes for size=2; the byte enables pick the lane.
    function automatic logic [63:0] amo_compute(hpdcache_req_op_t op, logic [2:0] size,
                                                logic [7:0] be, logic [63:0] old,
                                                logic [63:0] operand);
        logic        hi;
        logic [31:0] lane_a, lane_b;
        logic [63:0] sa, sb, ua, ub, r;
        hi     = (be[7:4] != 4'h0) && (be[3:0] == 4'h0);
        lane_a = hi ? old[63:32] : old[31:0];
        lane_b = hi ? operand[63:32] : operand[31:0];
        if (size == 3'd3) begin
            sa = old;
            sb = operand;
            ua = old;
            ub = operand;
        end else begin
            sa = {{32{lane_a[31]}}, lane_a};
            sb = {{32{lane_b[31]}}, lane_b};
            ua = {32'h0, lane_a};
            ub = {32'h0, lane_b};
        end
        case (op)
            HPDCACHE_REQ_AMO_SWAP: r = ub;
            HPDCACHE_REQ_AMO_ADD:  r = ua + ub;
            HPDCACHE_REQ_AMO_AND:  r = ua & ub;
            HPDCACHE_REQ_AMO_OR:   r = ua | ub;
            HPDCACHE_REQ_AMO_XOR:  r = ua ^ ub;
            HPDCACHE_REQ_AMO_MAX:  r = ($signed(sa) > $signed(sb)) ? ua : ub;
            HPDCACHE_REQ_AMO_MAXU: r = (ua > ub) ? ua : ub;
            HPDCACHE_REQ_AMO_MIN:  r = ($signed(sa) < $signed(sb)) ? ua : ub;
            HPDCACHE_REQ_AMO_MINU: r = (ua < ub) ? ua : ub;
            default:               r = ua;
        endcase
        return (size == 3'd3) ? r : {r[31:0], r[31:0]};
    endfunction

endpackage

// File: rtl/dcache_tcm_rsp_pipe.sv
// Fixed LATENCY-stage response delay line; output is the last stage.
// No backpressure: every stage shifts every cycle.
module dcache_tcm_rsp_pipe
    import drac_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           push_vld,
    input  tcm_rsp_entry_t push_entry,
    output tcm_rsp_entry_t out_entry
);

    tcm_rsp_entry_t stage [LATENCY];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= push_vld ? push_entry : '0;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_entry = stage[LATENCY-1];

endmodule

// File: rtl/dcache_tcm_responder.sv
// TCM responder: loads/stores/AMOs on local SRAM, responses after LATENCY cycles (AMO +1).
// Backpressure: req_ready_o drops only for the AMO write cycle; responses cannot be stalled.
module dcache_tcm_responder
    import drac_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int WBUF_DRAIN = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  hpdcache_req_t req_i,
    output logic          rsp_valid_o,
    output hpdcache_rsp_t rsp_o,
    output logic          wbuf_empty_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WBUF_DRAIN + 1);

    logic [63:0]      mem [DEPTH];
    tcm_fsm_t         state;
    logic             ready_q;
    logic             accept, req_oob, sc_ok, wbuf_load;
    logic [IDX_W-1:0] req_idx;
    logic [63:0]      rd_word;

    hpdcache_req_op_t amo_op;
    logic [2:0]       amo_size;
    logic [7:0]       amo_be;
    logic [63:0]      amo_operand, amo_old;
    logic [IDX_W-1:0] amo_idx;
    logic             amo_err, amo_need_rsp;
    logic [TID_W-1:0] amo_tid;
    logic [SID_W-1:0] amo_sid;

    logic             resv_vld;
    logic [IDX_W-1:0] resv_idx;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [63:0]      wr_data;
    logic [7:0]       wr_be;
    logic             push_vld;
    tcm_rsp_entry_t   push_entry, out_entry;
    logic [CNT_W-1:0] drain_cnt;
    logic             unused_req;

    assign unused_req  = ^{req_i.uncacheable, req_i.addr[2:0]};
    assign req_ready_o = ready_q;
    assign accept      = req_valid_i & ready_q & rstn_i;
    assign req_idx     = req_i.addr[IDX_W+2:3];
    assign req_oob     = |req_i.addr[ADDR_W-1:IDX_W+3];
    assign rd_word     = req_oob ? '0 : mem[req_idx];
    assign sc_ok       = resv_vld && (resv_idx == req_idx) && !req_oob;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = req_idx;
        wr_data = req_i.wdata;
        wr_be   = req_i.be;
        if (state == AMO_WR) begin
            wr_en   = !amo_err;
            wr_idx  = amo_idx;
            wr_data = amo_compute(amo_op, amo_size, amo_be, amo_old, amo_operand);
            wr_be   = amo_be;
        end else if (accept && !req_oob) begin
            wr_en = (req_i.op == HPDCACHE_REQ_STORE) || (req_i.op == HPDCACHE_REQ_AMO_SC && sc_ok);
        end
    end

    // SRAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        push_vld   = 1'b0;
        push_entry = '0;
        if (state == AMO_WR) begin
            push_vld         = amo_need_rsp;
            push_entry.tid   = amo_tid;
            push_entry.sid   = amo_sid;
            push_entry.rdata = amo_err ? '0 : amo_old;
            push_entry.error = amo_err;
        end else if (accept && !is_amo_rmw(req_i.op)) begin
            push_vld         = req_i.need_rsp;
            push_entry.tid   = req_i.tid;
            push_entry.sid   = req_i.sid;
            push_entry.error = req_oob;
            if (!req_oob) begin
                case (req_i.op)
                    HPDCACHE_REQ_LOAD, HPDCACHE_REQ_AMO_LR: push_entry.rdata = rd_word;
                    HPDCACHE_REQ_AMO_SC: push_entry.rdata = {63'd0, !sc_ok};
                    default:             push_entry.rdata = '0;
                endcase
            end
        end
        push_entry.valid = push_vld;
    end

    assign wbuf_load = (accept && req_i.op == HPDCACHE_REQ_STORE) || (state == AMO_WR) ||
                       (accept && req_i.op == HPDCACHE_REQ_AMO_SC && sc_ok);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            ready_q      <= 1'b1;
            amo_op       <= HPDCACHE_REQ_LOAD;
            amo_size     <= '0;
            amo_be       <= '0;
            amo_operand  <= '0;
            amo_old      <= '0;
            amo_idx      <= '0;
            amo_err      <= 1'b0;
            amo_need_rsp <= 1'b0;
            amo_tid      <= '0;
            amo_sid      <= '0;
            resv_vld     <= 1'b0;
            resv_idx     <= '0;
            drain_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_amo_rmw(req_i.op)) begin
                        state        <= AMO_WR;
                        ready_q      <= 1'b0;
                        amo_op       <= req_i.op;
                        amo_size     <= req_i.size;
                        amo_be       <= req_i.be;
                        amo_operand  <= req_i.wdata;
                        amo_old      <= rd_word;
                        amo_idx      <= req_idx;
                        amo_err      <= req_oob;
                        amo_need_rsp <= req_i.need_rsp;
                        amo_tid      <= req_i.tid;
                        amo_sid      <= req_i.sid;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase

            // Any write to the reserved word, and every SC, kills the reservation.
            if (accept && req_i.op == HPDCACHE_REQ_AMO_LR && !req_oob) begin
                resv_vld <= 1'b1;
                resv_idx <= req_idx;
            end else if ((accept && req_i.op == HPDCACHE_REQ_AMO_SC) ||
                         (wr_en && resv_vld && wr_idx == resv_idx)) begin
                resv_vld <= 1'b0;
            end

            if (wbuf_load) drain_cnt <= CNT_W'(WBUF_DRAIN);
            else if (drain_cnt != '0) drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    assign wbuf_empty_o = (drain_cnt == '0);

    dcache_tcm_rsp_pipe #(.LATENCY(LATENCY)) u_rsp_pipe (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .push_vld   (push_vld),
        .push_entry (push_entry),
        .out_entry  (out_entry)
    );

    assign rsp_valid_o = out_entry.valid;
    assign rsp_o = '{rdata: out_entry.rdata, sid: out_entry.sid,
                     tid: out_entry.tid, error: out_entry.error};

    req_stable_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (req_valid_i && !req_ready_o) |=> $stable(req_i));
    amo_size_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (req_valid_i && is_amo(req_i.op)) |-> (req_i.size <= 3'd3));

endmodule

// File: doc/dcache_tcm_responder.md
Name: dcache_tcm_responder

Overview:
- Responder end of the core-to-HPDCache request/response protocol. Used as a tightly-coupled data memory model and standalone test target in place of the HPDCache.
- Accepts hpdcache_req_t requests with a valid/ready handshake. Executes loads, stores and AMOs (LR/SC included) on a local SRAM.
- Returns tid-tagged hpdcache_rsp_t responses after a fixed latency. Drives the write-buffer-empty indication used for ordering.

Parameters:
- DEPTH, 1024, number of 64-bit memory words (power of two).
- LATENCY, 2, cycles from request acceptance to rsp_valid_o (1..8).
- WBUF_DRAIN, 4, cycles wbuf_empty_o stays low after the last accepted store/AMO/SC.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid (core_req_valid_o of the initiator).
- req_ready_o  out  1  request ready.
- req_i  in  hpdcache_req_t  op, addr, be, wdata, size, sid, tid, need_rsp, uncacheable.
- rsp_valid_o  out  1  response valid; no backpressure.
- rsp_o  out  hpdcache_rsp_t  rdata, sid, tid, error.
- wbuf_empty_o  out  1  no store is draining.

Behaviour:
- Reset values:
  - req_ready_o=1, rsp_valid_o=0, rsp_o='0, wbuf_empty_o=1.
  - Delay line cleared, reservation invalid, FSM=IDLE.
  - SRAM contents are not reset.
- Accept = req_valid_i & req_ready_o. At most one accept per cycle.
- Word index = addr[log2(DEPTH)+2:3]. If any address bit above that range is nonzero: no SRAM write, error=1, rdata=0.
- LOAD: rdata = full 64-bit word, unshifted. The core aligns.
- STORE: byte-enable write of wdata in the accept cycle; rdata=0.
- FSM IDLE/AMO_WR, for AMO ops:
  - IDLE: accepting an AMO (not LR/SC) latches the old word, goes to AMO_WR, req_ready_o=0.
  - AMO_WR: writes op(old, wdata) under be, returns to IDLE.
  - AMO throughput is one per 2 cycles. rdata = old word.
- AMO width rules:
  - size=2: operate on the 32-bit lane selected by be.
  - MIN/MAX compare sign-extended 32-bit values; MINU/MAXU compare zero-extended.
  - size=3: 64-bit operands.
- AMO_LR: load plus set reservation {valid, word index}.
- AMO_SC:
  - Success only if the reservation is valid and its index matches: write under be, rdata=0.
  - Otherwise no write, rdata=1.
  - The reservation is cleared either way.
- Any STORE or AMO write to the reserved index clears the reservation. LR in the same cycle as a clearing event is not possible (single issue).
- Response pipeline:
  - Shift register of LATENCY entries holding {valid, tid, sid, rdata, error}.
  - Entry written at accept (for AMO, at the AMO_WR cycle with old data) when need_rsp=1.
  - rsp_valid_o/rsp_o come from the last stage. The AMO response arrives LATENCY+1 cycles after accept.
- uncacheable is accepted and ignored (same timing).
- wbuf_empty_o:
  - Counter loads WBUF_DRAIN on each STORE/AMO/successful-SC write.
  - Decrements to 0; wbuf_empty_o = (counter==0).
  - A new store reloads the counter; no accumulation.
- Asynchronous reset mid-operation:
  - In-flight responses are dropped, the FSM aborts AMO_WR (the write is lost), the reservation is cleared.
- Assertions (simulation only): req_i stable while req_valid_i & ~req_ready_o; size ≤ 3 for AMO.

Decomposition:
- In hpdcache-aligned package drac_pkg: typedef tcm_fsm_t {IDLE, AMO_WR}, typedef tcm_rsp_entry_t, function amo_compute(op, size, be, old, operand).
- Sub-module dcache_tcm_rsp_pipe: parameterised LATENCY delay line of tcm_rsp_entry_t.

Test Plan:
- STORE addr 0x40, be=0xFF, wdata=0x1122334455667788, tid=5; then LOAD 0x40, tid=6 -> rsp tid=6 two cycles after accept, rdata=0x1122334455667788, error=0.
- STORE addr 0x41, be=0x02, wdata=0xAB00 on a word of zeros -> subsequent LOAD returns 0x000000000000AB00; wbuf_empty_o low for 4 cycles after the store.
- AMO_ADD size=2, be=0xF0, wdata=0x00000001_00000000 on word 0xFFFFFFFF_00000010 -> rdata=old word, new word 0x00000000_00000010, req_ready_o=0 for exactly one cycle, rsp 3 cycles after accept.
- LR 0x80, SC 0x80 -> SC rdata=0, memory written. Then LR 0x80, STORE 0x80, SC 0x80 -> SC rdata=1, memory unchanged by the SC.
- LOAD to addr DEPTH*8 -> error=1, rdata=0. STORE out of range -> SRAM unchanged.
- Back-to-back loads tid 1,2,3, reset asserted the cycle after tid 3 accept -> no responses after reset, req_ready_o=1, wbuf_empty_o=1; a new load after release responds normally.
